// File: rtl/display_scanner.sv
// Time-multiplexed N-digit segment display scanner with per-digit PWM brightness,
// blink masking and frame-synchronous (tear-free) loading of new segment data.
module display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8,
  parameter int PRESCALE   = 1,
  parameter int DUTY_W     = 3,
  parameter int BLINK_W    = 6
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       blink,
  input  logic [DUTY_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]       digits,
  output logic [SEG_W-1:0]            segments,
  output logic                        load_ack,
  output logic                        frame_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]               r_presc;
  logic [DUTY_W-1:0]           r_sub;
  logic [IW-1:0]               r_idx;
  logic [BLINK_W-1:0]          r_frame;
  logic                        r_blink_phase;
  logic                        r_pending;
  logic [NUM_DIGITS*SEG_W-1:0] r_active;
  logic [NUM_DIGITS*SEG_W-1:0] r_staging;
  logic [NUM_DIGITS-1:0]       r_digits;
  logic [SEG_W-1:0]            r_segments;
  logic                        r_load_ack;
  logic                        r_frame_start;

  logic             w_tick;
  logic             w_sub_wrap;
  logic             w_idx_last;
  logic             w_frame;
  logic             w_lit;
  logic [SEG_W-1:0] w_cur_seg;

  assign w_tick     = (r_presc == PW'(PRESCALE - 1));
  assign w_sub_wrap = w_tick && (r_sub == {DUTY_W{1'b1}});
  assign w_idx_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame    = w_sub_wrap && w_idx_last;

  // The all-ones sub-slot can never satisfy sub < brightness, giving the dead time.
  assign w_lit     = (r_sub < brightness) && digit_en[r_idx] &&
                     !(blink[r_idx] && r_blink_phase);
  assign w_cur_seg = r_active[r_idx*SEG_W +: SEG_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc       <= '0;
      r_sub         <= '0;
      r_idx         <= '0;
      r_frame       <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_sub <= r_sub + 1'b1;
      if (w_sub_wrap) r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      if (w_frame) begin
        r_frame <= r_frame + 1'b1;
        if (r_frame == {BLINK_W{1'b1}}) r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // Data swaps only at the frame boundary; a load landing on the boundary bypasses staging.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= 1'b0;
      r_active      <= '0;
      r_staging     <= '0;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame;
      r_load_ack    <= 1'b0;
      if (w_frame) begin
        if (load) begin
          r_active   <= seg_data;
          r_load_ack <= 1'b1;
        end else if (r_pending) begin
          r_active   <= r_staging;
          r_load_ack <= 1'b1;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_staging <= seg_data;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_digits   <= '1;
      r_segments <= '1;
    end else begin
      r_digits   <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_segments <= w_lit ? ~w_cur_seg : '1;
    end
  end

  assign digits      = r_digits;
  assign segments    = r_segments;
  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner; expected outputs come from a cycle-count
// based reference model (position in frame derived arithmetically from time since reset).
module tb_display_scanner;

  localparam int N     = 4;
  localparam int SW    = 8;
  localparam int P     = 1;
  localparam int DW    = 3;
  localparam int BW    = 2;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = N * SLOT * P;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*SW-1:0] seg_data;
  logic            load;
  logic [N-1:0]    digit_en;
  logic [N-1:0]    blink;
  logic [DW-1:0]   brightness;
  logic [N-1:0]    digits;
  logic [SW-1:0]   segments;
  logic            load_ack;
  logic            frame_start;

  display_scanner #(
    .NUM_DIGITS(N), .SEG_W(SW), .PRESCALE(P), .DUTY_W(DW), .BLINK_W(BW)
  ) dut (
    .clock(clk), .reset_n(rst_n), .seg_data(seg_data), .load(load),
    .digit_en(digit_en), .blink(blink), .brightness(brightness),
    .digits(digits), .segments(segments), .load_ack(load_ack),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: cycles since reset plus the data-path contents.
  int              m_t;
  logic [N*SW-1:0] m_active;
  logic [N*SW-1:0] m_staging;
  logic            m_pending;
  int              ack_count;
  int              first_ack_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %h expected %h", tag, m_t, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_active  = '0;
    m_staging = '0;
    m_pending = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0]  ed;
    logic [SW-1:0] es;
    logic          ea, ef;
    int            pos, tk, sub, idx, phase;
    logic          lit, boundary;
    @(posedge clk);
    ed = '1; es = '1; ea = 1'b0; ef = 1'b0;
    if (rst_n) begin
      pos      = m_t % FRAME;
      tk       = pos / P;
      sub      = tk % SLOT;
      idx      = tk / SLOT;
      phase    = ((m_t / FRAME) >> BW) & 1;
      boundary = (pos == FRAME - 1);
      lit      = (sub < int'(brightness)) && digit_en[idx] && !(blink[idx] && phase == 1);
      if (lit) begin
        ed = '1;
        ed[idx] = 1'b0;
        es = ~m_active[idx*SW +: SW];
      end
      ef = boundary;
      ea = boundary && (load || m_pending);
      if (boundary) begin
        if (load) m_active = seg_data;
        else if (m_pending) m_active = m_staging;
        m_pending = 1'b0;
      end else if (load) begin
        m_staging = seg_data;
        m_pending = 1'b1;
      end
      m_t++;
    end
    #1;
    chk("digits", 32'(digits), 32'(ed));
    chk("segments", 32'(segments), 32'(es));
    chk("load_ack", 32'(load_ack), 32'(ea));
    chk("frame_start", 32'(frame_start), 32'(ef));
    if (load_ack === 1'b1) begin
      ack_count++;
      if (first_ack_t < 0) first_ack_t = m_t;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    seg_data = '0; load = 1'b0; digit_en = '1; blink = '0; brightness = '0;
    ack_count = 0; first_ack_t = -1;
    do_reset();

    // Dark display with brightness zero.
    run(64);

    // First load mid-frame; acknowledged at the frame boundary.
    do_reset();
    brightness = 3'd7; ack_count = 0; first_ack_t = -1;
    while (m_t < 5) step();
    seg_data = 32'h3F06_5B4F; load = 1'b1;
    step();
    load = 1'b0;
    run(3 * FRAME);
    chk("first_ack_cycle", 32'(first_ack_t), 32'd32);
    chk("first_ack_count", 32'(ack_count), 32'd1);

    // Three loads inside one frame collapse to a single acknowledge.
    while (m_t % FRAME != 3) step();
    ack_count = 0;
    for (int k = 0; k < 3; k++) begin
      seg_data = {$urandom}; load = 1'b1; step();
      load = 1'b0; run(4);
    end
    while (m_t % FRAME != 2) step();
    chk("triple_load_acks", 32'(ack_count), 32'd1);

    // Load exactly on the boundary cycle bypasses staging.
    while (m_t % FRAME != FRAME - 1) step();
    ack_count = 0;
    seg_data = 32'hA55A_1234; load = 1'b1; step();
    load = 1'b0;
    chk("boundary_load_ack", 32'(ack_count), 32'd1);
    run(FRAME);

    // Blink on digit 1 over several blink periods.
    blink = 4'b0010;
    run(16 * FRAME);
    blink = '0;

    // Randomized traffic with live control changes.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 7) == 0);
      seg_data = {$urandom};
      if ($urandom_range(0, 63) == 0) begin
        digit_en   = N'($urandom);
        blink      = N'($urandom);
        brightness = DW'($urandom);
      end
      step();
    end
    load = 1'b0;

    // Asynchronous reset mid-frame with a load pending.
    digit_en = '1; blink = '0; brightness = 3'd5;
    while (m_t % FRAME != 10) step();
    seg_data = 32'hDEAD_BEEF; load = 1'b1; step();
    load = 1'b0; run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_digits", 32'(digits), 32'hF);
    chk("async_segments", 32'(segments), 32'hFF);
    chk("async_ack", 32'(load_ack), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    ack_count = 0;
    step();
    chk("restart_digit0", 32'(digits), 32'hE);
    run(2 * FRAME);
    chk("no_ack_after_reset", 32'(ack_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SEG_W, default 8: segment lines per digit, 7 segments plus dp.
REQ-003 Parameter PRESCALE, default 1: clock cycles per scan tick, legal minimum 1.
REQ-004 Parameter DUTY_W, default 3: width of the brightness code; each digit slot is 2^DUTY_W ticks.
REQ-005 Parameter BLINK_W, default 6: width of the frame counter that sets the blink period.
REQ-006 clock  in  1  the single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 seg_data  in  NUM_DIGITS*SEG_W  active-high segment patterns; digit k occupies bits [k*SEG_W +: SEG_W].
REQ-009 load  in  1  request to capture seg_data.
REQ-010 digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-011 blink  in  NUM_DIGITS  per-digit blink mask.
REQ-012 brightness  in  DUTY_W  on-time per slot, in ticks.
REQ-013 digits  out  NUM_DIGITS  active-low digit select; at most one bit is low.
REQ-014 segments  out  SEG_W  active-low segment drive.
REQ-015 load_ack  out  1  one-cycle pulse when the captured data becomes the displayed data.
REQ-016 frame_start  out  1  one-cycle pulse at the start of each scan frame.

Function
REQ-017 A prescaler shall count 0..PRESCALE-1 and assert tick in the cycle where it holds PRESCALE-1, then wrap to 0.
REQ-018 On each tick, a sub-slot counter sub shall advance 0..2^DUTY_W-1 and wrap.
REQ-019 When sub wraps, the digit index idx shall advance 0..NUM_DIGITS-1 and wrap.
REQ-020 The frame boundary is the tick where sub and idx both wrap; a frame lasts NUM_DIGITS*2^DUTY_W*PRESCALE cycles.
REQ-021 Digit idx shall be lit when all of the following hold: sub < brightness; digit_en[idx]=1; and not (blink[idx]=1 and blink_phase=1).
REQ-022 When the digit is lit: digits = ~(1<<idx) and segments = ~active[idx]. Otherwise digits and segments are all ones.
REQ-023 brightness=0 shall keep the display dark. Sub-slot 2^DUTY_W-1 is always dark, which gives the anti-ghosting dead time.
REQ-024 digits and segments shall be registered and lag the counter state by exactly 1 cycle.
REQ-025 load=1 with no frame boundary in that cycle shall copy seg_data into the staging register and set pending.
REQ-026 Further loads while pending shall overwrite staging; the latest data wins.
REQ-027 At a frame boundary with pending=1: active <= staging, pending <= 0, and load_ack pulses in the next cycle.
REQ-028 load=1 in a frame-boundary cycle: active <= seg_data of that cycle directly, pending <= 0, and load_ack pulses in the next cycle.
REQ-029 At a frame boundary with no pending data and load=0, active is unchanged and load_ack stays 0.
REQ-030 frame_start shall pulse in the cycle after every frame boundary, coincident with any load_ack.
REQ-031 A BLINK_W-bit frame counter shall increment at each frame boundary; blink_phase toggles when that counter wraps.
REQ-032 digit_en, blink and brightness shall be sampled live each cycle and are not double-buffered.

Reset
REQ-033 While reset_n=0: prescaler, sub, idx, frame counter, blink_phase, pending, active and staging are all 0.
REQ-034 While reset_n=0: digits and segments are all ones; load_ack and frame_start are 0.
REQ-035 Deasserting reset mid-frame shall restart the scan from idx 0, sub 0, and discard any pending load.

Verification (defaults, PRESCALE=1, BLINK_W=2)
REQ-036 Reset, then digit_en=4'hF and brightness=0 for 64 cycles -> digits=4'hF and segments=8'hFF in every cycle.
REQ-037 load pulse with seg_data=32'h3F06_5B4F at cycle 5, brightness=7, digit_en=4'hF ->
- load_ack and frame_start pulse at cycle 32;
- digit0 is then low for 7 of every 8 cycles with segments=8'hB0;
- digits step through 0..3 with a period of 32 cycles.
REQ-038 Three loads with distinct data inside one frame -> a single load_ack, and the last data is displayed.
REQ-039 load asserted exactly on a frame-boundary cycle -> that cycle's data is displayed from the next frame slot, with no extra frame of delay.
REQ-040 blink=4'b0010 -> digit1 is dark for 4 frames, lit for 4 frames, repeating; the other digits are unaffected.
REQ-041 reset_n pulsed low for 1 cycle mid-frame with a load pending ->
- outputs go all ones asynchronously;
- no load_ack follows;
- after release, the scan restarts at digit0.
